// File: rtl/dmem_initiator_if.sv
// CPU-side load/store request/response channel plus the data-cache access lines.
interface dmem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_read_data, mem_clk_stall,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_read_data, mem_clk_stall,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
  );
endinterface

// File: rtl/dmem_initiator.sv
// Load/store initiator: issues one pipeline op to the data cache, follows its
// clk_stall handshake and returns a single-cycle response (error on bad op/timeout).
module dmem_initiator #(
  parameter int unsigned STALL_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  dmem_initiator_if.master bus
);
  localparam int unsigned   CW       = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STALL_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STALL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    mask_q, mask_d;
  logic          write_q, write_d;
  logic          err_q, err_d;
  logic          req_ready;
  logic          accept;
  logic          dec_err;
  logic [3:0]    dec_mask;

  // The cache is not reset with us, so never accept while it still stalls.
  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE) && !bus.mem_clk_stall;
    accept    = bus.req_valid && req_ready;
  end

  always_comb begin
    dec_mask = '0;
    dec_err  = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   dec_mask[2:0] = 3'b001;
      2'b01: begin
        dec_mask[2:0] = 3'b011;
        dec_err       = bus.req_addr[0];
      end
      2'b10: begin
        dec_mask[2:0] = 3'b111;
        dec_err       = |bus.req_addr[1:0];
      end
      default: dec_err = 1'b1;
    endcase
    // Only loads have 1xx encodings, and only the unsigned B/H ones.
    if (bus.req_funct3[2] && (bus.req_write || bus.req_funct3[1])) dec_err = 1'b1;
    dec_mask[3] = !bus.req_write && !bus.req_funct3[2] && !bus.req_funct3[1];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mask_d  = mask_q;
    write_d = write_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          mask_d  = dec_mask;
          err_d   = dec_err;
          if (dec_err) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (bus.mem_clk_stall) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_WAIT_LO: begin
        if (!bus.mem_clk_stall) begin
          rdata_d = write_q ? '0 : bus.mem_read_data;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mask_q  <= mask_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.req_ready      = req_ready;
    bus.busy           = (state_q != S_IDLE);
    bus.rsp_valid      = (state_q == S_RESP);
    bus.rsp_err        = (state_q == S_RESP) && err_q;
    bus.rsp_rdata      = rdata_q;
    bus.mem_memread    = (state_q == S_ISSUE) && !write_q;
    bus.mem_memwrite   = (state_q == S_ISSUE) && write_q;
    bus.mem_addr       = addr_q;
    bus.mem_write_data = wdata_q;
    bus.mem_sign_mask  = mask_q;
  end
endmodule
